// File: rtl/result_reader.sv
// Streams an N_DIM x N_DIM matrix out of four quadrant-banked datamemories,
// one element per valid/ready handshake, in row-major order.
module result_reader #(
    parameter int N_DIM      = 4,
    parameter int BASE_ADDR  = 4,
    parameter int ROW_STRIDE = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [11:0] addr_o,
    output logic [3:0]  we_o,
    input  logic [11:0] dataout1,
    input  logic [11:0] dataout2,
    input  logic [11:0] dataout3,
    input  logic [11:0] dataout4,
    output logic [11:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [2:0]  fsm_state
);

    localparam int CW = (N_DIM > 2) ? $clog2(N_DIM) : 1;
    localparam logic [CW-1:0] HALF = CW'(N_DIM / 2);
    localparam logic [CW-1:0] LAST = CW'(N_DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [11:0]   bank_data;

    assign we_o      = 4'b0000;
    assign fsm_state = state;

    // Counters only move on a handshake, so the address is stable ADDR..SEND.
    assign addr_o = 12'(BASE_ADDR) + 12'(row) * 12'(ROW_STRIDE) + 12'(col);

    // Quadrant to bank mapping: TL=1, TR=4, BL=3, BR=2.
    always_comb begin
        bank_data = '0;
        case ({row >= HALF, col >= HALF})
            2'b00:   bank_data = dataout1;
            2'b01:   bank_data = dataout4;
            2'b10:   bank_data = dataout3;
            default: bank_data = dataout2;
        endcase
    end

    // Valid/ready: out_valid rises in SEND and stays high, with out_data and
    // out_last frozen, until out_valid && out_ready are both seen at a rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        row   <= '0;
                        col   <= '0;
                        busy  <= 1'b1;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: state <= S_CAPT;
                S_CAPT: begin
                    out_data  <= bank_data;
                    out_valid <= 1'b1;
                    out_last  <= (row == LAST) && (col == LAST);
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            if (col == LAST) begin
                                col <= '0;
                                row <= row + CW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                            state <= S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 SHALL have parameter N_DIM, default 4: matrix dimension; even, 2..64.
REQ-002 SHALL have parameter BASE_ADDR, default 4: word address of element (0,0).
REQ-003 SHALL have parameter ROW_STRIDE, default 64: address increment per matrix row.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request one full matrix readout.
REQ-007 SHALL have port addr_o, output, 12: address driven to all four datamemory address ports.
REQ-008 SHALL have port we_o, output, 4: write enables to datamemory banks 1..4; constant 4'b0000.
REQ-009 SHALL have ports dataout1..dataout4, input, 12 each: registered read data from banks 1..4.
REQ-010 SHALL have port out_data, output, 12: streamed matrix element.
REQ-011 SHALL have port out_valid, output, 1: out_data holds a valid element.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-013 SHALL have port out_last, output, 1: asserted with out_valid on element (N_DIM-1, N_DIM-1).
REQ-014 SHALL have port busy, output, 1: readout in progress.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after final handshake.

Function
REQ-016 SHALL implement states IDLE, ADDR, CAPT, SEND, DONE.
REQ-017 In IDLE with start=1: row=col=0, busy=1, next state ADDR.
- start SHALL be ignored in every state except IDLE.
REQ-018 SHALL drive addr_o = BASE_ADDR + row*ROW_STRIDE + col, truncated to 12 bits, combinationally from the row/col counters.
- addr_o SHALL be held stable from ADDR through SEND.
REQ-019 ADDR SHALL last exactly one cycle, then go to CAPT; datamemory samples addr_o on the edge that ends ADDR.
REQ-020 In CAPT, the edge ending the cycle SHALL load out_data from the selected bank; next state SEND.
- Bank selection, with h = N_DIM/2:
  - row<h, col<h: dataout1
  - row<h, col>=h: dataout4
  - row>=h, col<h: dataout3
  - row>=h, col>=h: dataout2
REQ-021 In SEND, out_valid SHALL be 1.
- out_data and out_last SHALL remain stable while out_ready=0.
REQ-022 A handshake is out_valid=1 and out_ready=1 at a rising edge.
- On a handshake, out_valid SHALL deassert on that edge.
- If out_last=1: next state DONE.
- Otherwise: advance in row-major order (col+1; at col=N_DIM-1, col=0 and row+1); next state ADDR.
REQ-023 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE with busy=0.
REQ-024 Timing: three cycles minimum per element; N_DIM*N_DIM handshakes per readout, no skipped or duplicated elements.
REQ-025 out_last SHALL be 1 only in SEND at row=col=N_DIM-1.
REQ-026 Counters SHALL be wide enough for N_DIM-1.
- Address arithmetic SHALL wrap modulo 4096 without error.

Reset
REQ-027 With rst_n=0 at a rising edge, the block SHALL enter IDLE.
- out_valid=0, out_last=0, busy=0, done=0, out_data=0, row=col=0.
REQ-028 Reset in any state, mid-readout included, SHALL abort the readout with no further handshakes and no done pulse.
REQ-029 we_o SHALL be 4'b0000 in and out of reset.

Verification
REQ-030 Defaults, banks preloaded with value = address (low 12 bits), out_ready=1, pulse start:
- 16 elements in order 4,5,6,7,68,69,70,71,132,...,199.
- Elements 0,1,4,5 taken from dataout1.
- out_last only on element 199.
- done pulses 1 cycle after the last handshake.
REQ-031 out_ready=0 for 5 cycles on element 2: out_data=6 held, out_valid=1 throughout; element 3 (7) follows with no loss.
REQ-032 start re-pulsed while busy: ignored, exactly 16 handshakes, a single done pulse.
REQ-033 rst_n=0 for one cycle during SEND of element 9: out_valid=0 next cycle, busy=0, no done pulse.
- A subsequent start restarts at address 4.
REQ-034 N_DIM=2, BASE_ADDR=4094, ROW_STRIDE=64: addresses 4094, 4095, 62, 63 (wrap).
- Element sources in order: dataout1, dataout4, dataout3, dataout2.
REQ-035 Throughout all scenarios: we_o = 0, and addr_o is constant from ADDR to the handshake.
